data_sym_mod: RTL and testbench



---
 rtl/data_sym_mod_pkg.sv | 27 ++
 rtl/data_sym_mod_qpsk_map.sv | 19 +
 rtl/data_sym_mod.sv | 130 +++++++++++++
 tb/tb_data_sym_mod.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sym_mod_pkg.sv
// Shared widths, amplitude constant and symbol layout for the QPSK data-symbol mapper.
// Contents: BYTE_W/SYM_W/HALF_W/DIBIT_W/CNT_W/SYM_CNT_W widths, QPSK_AMP_Q14 level,
//           sym_t symbol payload {im, re}, qpsk_level() sign helper.
package data_sym_mod_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned SYM_W     = 32;
    localparam int unsigned HALF_W    = 16;
    localparam int unsigned DIBIT_W   = 2;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned SYM_CNT_W = 16;

    // 0.7071 in Q1.14
    localparam logic [HALF_W-1:0] QPSK_AMP_Q14 = 16'h2D41;

    // Complex symbol as presented to the IFFT/framer: Im in the upper half
    typedef struct packed {
        logic [HALF_W-1:0] im;
        logic [HALF_W-1:0] re;
    } sym_t;

    // A set bit selects the negative (two's complement) level
    function automatic logic [HALF_W-1:0] qpsk_level(input logic neg, input logic [HALF_W-1:0] amp);
        return neg ? (~amp + HALF_W'(1)) : amp;
    endfunction

endpackage

// File: rtl/data_sym_mod_qpsk_map.sv
// Combinational QPSK dibit-to-symbol mapper.
// Ports: dibit_i [1:0] dibit (bit1 -> Im sign, bit0 -> Re sign, 1 = negative)
//        sym_o   [31:0] symbol {Im[15:0], Re[15:0]}
// Parameter AMP: symbol magnitude in Q1.14.
module qpsk_map
    import data_sym_mod_pkg::*;
#(
    parameter logic [HALF_W-1:0] AMP = QPSK_AMP_Q14
) (
    input  logic [DIBIT_W-1:0] dibit_i,
    output sym_t               sym_o
);

    always_comb begin
        sym_o.re = qpsk_level(dibit_i[0], AMP);
        sym_o.im = qpsk_level(dibit_i[1], AMP);
    end

endmodule

// File: rtl/data_sym_mod.sv
// QPSK data-symbol mapper: unpacks bytes received on a Wishbone-style streaming slave
// into dibits (LSB dibit first) and emits one complex symbol per dibit on a streaming master.
// Ports: clk_i, rst_ni (async, active-low)
//        slave : DAT_I[7:0], WE_I, STB_I, CYC_I in; ACK_O out (combinational)
//        master: DAT_O[31:0] {Im,Re}, CYC_O, STB_O, WE_O (= STB_O) out; ACK_I in
//        SYM_CNT_O[15:0] out, only when DATA_SYM_MOD_CNT_EN is defined (handed-off symbol count)
// Parameters: SYMS_PER_BYTE (1 or 4), AMP (Q1.14 magnitude).
// Build option: DATA_SYM_MOD_CNT_EN adds the handed-off symbol counter.
module data_sym_mod
    import data_sym_mod_pkg::*;
#(
    parameter int unsigned       SYMS_PER_BYTE = 4,
    parameter logic [HALF_W-1:0] AMP           = QPSK_AMP_Q14
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [BYTE_W-1:0]    DAT_I,
    input  logic                 WE_I,
    input  logic                 STB_I,
    input  logic                 CYC_I,
    output logic                 ACK_O,
    output logic [SYM_W-1:0]     DAT_O,
    output logic                 CYC_O,
    output logic                 STB_O,
    output logic                 WE_O,
    input  logic                 ACK_I
`ifdef DATA_SYM_MOD_CNT_EN
    ,
    output logic [SYM_CNT_W-1:0] SYM_CNT_O
`endif
);

    sym_t              dat_q, dat_d;
    logic              stb_q, stb_d;
    logic              cyc_q, cyc_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    sym_t              sym_c;
    logic              out_halt_c, ena_c, ack_c;

    qpsk_map #(.AMP(AMP)) u_map (
        .dibit_i (shift_q[DIBIT_W-1:0]),
        .sym_o   (sym_c)
    );

    // Accept only when the unpacker is empty or emitting its last dibit this cycle
    assign out_halt_c = stb_q & ~ACK_I;
    assign ena_c      = CYC_I & STB_I & WE_I;
    assign ack_c      = ena_c & ~out_halt_c & (cnt_q <= CNT_W'(1));

    // Next-state: emit/shift, byte load overrides the decrement, everything holds on stall
    always_comb begin
        dat_d   = dat_q;
        stb_d   = stb_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;

        if (!out_halt_c) begin
            if (cnt_q != '0) begin
                dat_d   = sym_c;
                stb_d   = 1'b1;
                shift_d = shift_q >> DIBIT_W;
                cnt_d   = cnt_q - CNT_W'(1);
            end else begin
                stb_d   = 1'b0;
            end
            if (ack_c) begin
                shift_d = DAT_I;
                cnt_d   = CNT_W'(SYMS_PER_BYTE);
            end
        end

        // Bus cycle stays open until the last symbol has been taken downstream
        if (CYC_I && (cnt_q != '0)) begin
            cyc_d = 1'b1;
        end else if (!CYC_I && !stb_q && (cnt_q == '0)) begin
            cyc_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dat_q   <= '0;
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            dat_q   <= dat_d;
            stb_q   <= stb_d;
            cyc_q   <= cyc_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ACK_O = ack_c;
    assign DAT_O = dat_q;
    assign STB_O = stb_q;
    assign WE_O  = stb_q;
    assign CYC_O = cyc_q;

`ifdef DATA_SYM_MOD_CNT_EN
    logic [SYM_CNT_W-1:0] sym_cnt_q, sym_cnt_d;

    // Counts handoffs, wraps naturally, restarts whenever the output cycle closes
    always_comb begin
        sym_cnt_d = sym_cnt_q;
        if (stb_q && ACK_I) begin
            sym_cnt_d = sym_cnt_q + SYM_CNT_W'(1);
        end
        if (cyc_q && !cyc_d) begin
            sym_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sym_cnt_q <= '0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
        end
    end

    assign SYM_CNT_O = sym_cnt_q;
`endif

endmodule

// File: tb/tb_data_sym_mod.sv
// Scoreboard bench for data_sym_mod: lane 0 is a 4-dibit-per-byte instance, lane 1 a
// 1-dibit-per-byte instance. Accepted bytes push reference symbols; a monitor pops them.
module tb_data_sym_mod;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  dat_i [2];
    logic        we_i  [2];
    logic        stb_i [2];
    logic        cyc_i [2];
    logic        ack_i [2];
    logic        ack_o [2];
    logic [31:0] dat_o [2];
    logic        cyc_o [2];
    logic        stb_o [2];
    logic        we_o  [2];
`ifdef DATA_SYM_MOD_CNT_EN
    logic [15:0] sym_cnt_o [2];
`endif

    data_sym_mod #(.SYMS_PER_BYTE(4)) u_dut4 (
        .clk_i (clk), .rst_ni (rst_n),
        .DAT_I (dat_i[0]), .WE_I (we_i[0]), .STB_I (stb_i[0]), .CYC_I (cyc_i[0]),
        .ACK_O (ack_o[0]), .DAT_O (dat_o[0]), .CYC_O (cyc_o[0]), .STB_O (stb_o[0]),
        .WE_O (we_o[0]), .ACK_I (ack_i[0])
`ifdef DATA_SYM_MOD_CNT_EN
        , .SYM_CNT_O (sym_cnt_o[0])
`endif
    );

    data_sym_mod #(.SYMS_PER_BYTE(1)) u_dut1 (
        .clk_i (clk), .rst_ni (rst_n),
        .DAT_I (dat_i[1]), .WE_I (we_i[1]), .STB_I (stb_i[1]), .CYC_I (cyc_i[1]),
        .ACK_O (ack_o[1]), .DAT_O (dat_o[1]), .CYC_O (cyc_o[1]), .STB_O (stb_o[1]),
        .WE_O (we_o[1]), .ACK_I (ack_i[1])
`ifdef DATA_SYM_MOD_CNT_EN
        , .SYM_CNT_O (sym_cnt_o[1])
`endif
    );

    localparam logic [15:0] POS = 16'h2D41;
    localparam logic [15:0] NEG = 16'hD2BF;   // 0x10000 - 0x2D41

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] sbq [2][$];
    logic [7:0]  txq [2][$];
    bit  cyc_en [2];
    int  ack_pct [2];
    int  stall [2];
    bit  we_noise;
    int  step_no = 0;
    int  ack_first [2];
    int  obs_lane, stb_cnt, first_stb, last_stb;
    bit  stall_arm;

    function automatic int spb(input int l);
        return (l == 0) ? 4 : 1;
    endfunction

    // Reference symbol: bit1 negates Im, bit0 negates Re
    function automatic logic [31:0] ref_sym(input logic [1:0] d);
        logic [15:0] re, im;
        re = d[0] ? NEG : POS;
        im = d[1] ? NEG : POS;
        return {im, re};
    endfunction

    task automatic push_byte(input int l, input logic [7:0] b);
        logic [7:0] t;
        t = b;
        for (int k = 0; k < spb(l); k++) begin
            sbq[l].push_back(ref_sym(t[1:0]));
            t = t >> 2;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s @%0t", name, $time);
    endtask

    // One clock of stimulus plus the ACK_O expectation derived from pending-symbol count
    task automatic step();
        int unem;
        bit halt, ena, exp;
        @(negedge clk);
        step_no++;
        for (int l = 0; l < 2; l++) begin
            cyc_i[l] = cyc_en[l];
            if (txq[l].size() > 0) begin
                stb_i[l] = 1'b1; we_i[l] = 1'b1; dat_i[l] = txq[l][0];
            end else if (we_noise && $urandom_range(3) == 0) begin
                stb_i[l] = 1'b1; we_i[l] = 1'b0; dat_i[l] = 8'($urandom);
            end else begin
                stb_i[l] = 1'b0; we_i[l] = 1'b0;
            end
            if (stall[l] > 0) begin
                ack_i[l] = 1'b0;
                stall[l]--;
            end else begin
                ack_i[l] = ($urandom_range(99) < ack_pct[l]);
            end
        end
        #1;
        for (int l = 0; l < 2; l++) begin
            halt = stb_o[l] & ~ack_i[l];
            ena  = cyc_i[l] & stb_i[l] & we_i[l];
            unem = sbq[l].size() - (stb_o[l] ? 1 : 0);
            exp  = ena & ~halt & (unem <= 1);
            check($sformatf("ack_o[%0d]", l), 32'(ack_o[l]), 32'(exp));
            if (exp) begin
                push_byte(l, txq[l].pop_front());
                if (ack_first[l] < 0) ack_first[l] = step_no;
            end
        end
    endtask

    task automatic obs();
        if (stb_o[obs_lane]) begin
            if (first_stb < 0) first_stb = step_no;
            last_stb = step_no;
            stb_cnt++;
        end
        for (int l = 0; l < 2; l++)
            if (stb_o[l]) check($sformatf("cyc_o_during_stb[%0d]", l), 32'(cyc_o[l]), 32'd1);
        if (stall_arm && stb_o[0] && dat_o[0] == {NEG, NEG}) begin
            stall[0] = 5;
            stall_arm = 1'b0;
        end
    endtask

    task automatic begin_phase(input int lane);
        obs_lane = lane;
        stb_cnt = 0;
        first_stb = -1;
        last_stb = -1;
        ack_first[0] = -1;
        ack_first[1] = -1;
    endtask

    task automatic run_drain(input int bound);
        int n;
        n = 0;
        while ((txq[0].size() + txq[1].size() + sbq[0].size() + sbq[1].size()) != 0 && n < bound) begin
            step();
            obs();
            n++;
        end
        if (n >= bound) fail_now("drain_timeout");
    endtask

    task automatic close_cycle();
        cyc_en[0] = 1'b0;
        cyc_en[1] = 1'b0;
        repeat (3) step();
        for (int l = 0; l < 2; l++)
            check($sformatf("cyc_o_closed[%0d]", l), 32'(cyc_o[l]), 32'd0);
        cyc_en[0] = 1'b1;
        cyc_en[1] = 1'b1;
    endtask

    // Output monitor: DAT_O must match the queue head whenever STB_O is up
    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int l = 0; l < 2; l++) begin
                if (stb_o[l]) begin
                    if (sbq[l].size() == 0) begin
                        fail_now($sformatf("unexpected_stb[%0d] got %h expected none", l, dat_o[l]));
                    end else begin
                        check($sformatf("dat_o[%0d]", l), dat_o[l], sbq[l][0]);
                        if (ack_i[l]) void'(sbq[l].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int l = 0; l < 2; l++) begin
            dat_i[l] = '0; we_i[l] = 1'b0; stb_i[l] = 1'b0; cyc_i[l] = 1'b0; ack_i[l] = 1'b0;
            cyc_en[l] = 1'b0; ack_pct[l] = 100; stall[l] = 0; ack_first[l] = -1;
        end
        we_noise = 1'b0;
        stall_arm = 1'b0;
        begin_phase(0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            for (int l = 0; l < 2; l++) begin
                check("rst_dat_o", dat_o[l], 32'd0);
                check("rst_stb_o", 32'(stb_o[l]), 32'd0);
                check("rst_cyc_o", 32'(cyc_o[l]), 32'd0);
                check("rst_ack_o", 32'(ack_o[l]), 32'd0);
            end
        end

        // Single byte 0x1B: latency and four contiguous symbols
        cyc_en[0] = 1'b1; cyc_en[1] = 1'b1;
        begin_phase(0);
        txq[0].push_back(8'h1B);
        run_drain(50);
        check("latency_1B", 32'(first_stb - ack_first[0]), 32'd2);
        check("stb_count_1B", 32'(stb_cnt), 32'd4);
        check("stb_contig_1B", 32'(last_stb - first_stb + 1), 32'd4);
        close_cycle();

        // Back-to-back 0x00, 0xFF, 0x55
        begin_phase(0);
        txq[0].push_back(8'h00); txq[0].push_back(8'hFF); txq[0].push_back(8'h55);
        run_drain(60);
        check("stb_count_stream", 32'(stb_cnt), 32'd12);
        check("stb_contig_stream", 32'(last_stb - first_stb + 1), 32'd12);

        // Same stream with a 5-cycle downstream stall inside the 0xFF byte
        begin_phase(0);
        stall_arm = 1'b1;
        txq[0].push_back(8'h00); txq[0].push_back(8'hFF); txq[0].push_back(8'h55);
        run_drain(80);
        check("stall_taken", 32'(stall_arm), 32'd0);
        check("stb_count_stall", 32'(stb_cnt), 32'd17);
        check("stb_contig_stall", 32'(last_stb - first_stb + 1), 32'd17);

        // One dibit per byte, upper bits ignored
        begin_phase(1);
        txq[1].push_back(8'h02); txq[1].push_back(8'h01); txq[1].push_back(8'hFE);
        run_drain(40);
        check("stb_count_spb1", 32'(stb_cnt), 32'd3);
        close_cycle();

        // Randomized traffic with backpressure and write-less strobes
        begin_phase(0);
        ack_pct[0] = 70; ack_pct[1] = 60;
        we_noise = 1'b1;
        for (int i = 0; i < 400; i++) begin
            for (int l = 0; l < 2; l++)
                if (txq[l].size() < 2 && $urandom_range(2) != 0) txq[l].push_back(8'($urandom));
            step();
            obs();
        end
        ack_pct[0] = 100; ack_pct[1] = 100;
        we_noise = 1'b0;
        begin
            int n;
            n = 0;
            while ((txq[0].size() + txq[1].size()) != 0 && n < 100) begin
                step(); obs(); n++;
            end
            if (n >= 100) fail_now("tx_drain_timeout");
        end
        // Drop CYC_I with symbols still pending: they must still come out
        cyc_en[0] = 1'b0; cyc_en[1] = 1'b0;
        run_drain(100);
        close_cycle();

        // Asynchronous reset mid-byte
        txq[0].push_back(8'hFF); txq[1].push_back(8'hFF);
        begin
            int n;
            n = 0;
            while (!stb_o[0] && n < 10) begin
                step(); n++;
            end
            if (n >= 10) fail_now("pre_reset_timeout");
        end
        step();
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            stb_i[l] = 1'b0; we_i[l] = 1'b0; cyc_i[l] = 1'b0;
        end
        #3;
        rst_n = 1'b0;
        #1;
        for (int l = 0; l < 2; l++) begin
            check("arst_dat_o", dat_o[l], 32'd0);
            check("arst_stb_o", 32'(stb_o[l]), 32'd0);
            check("arst_cyc_o", 32'(cyc_o[l]), 32'd0);
            check("arst_ack_o", 32'(ack_o[l]), 32'd0);
            sbq[l].delete();
            txq[l].delete();
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        begin_phase(0);
        txq[0].push_back(8'h00);
        run_drain(40);
        check("stb_count_after_rst", 32'(stb_cnt), 32'd4);
        close_cycle();

        for (int l = 0; l < 2; l++)
            check($sformatf("sb_empty[%0d]", l), 32'(sbq[l].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
